cdc_frame_arbiter: RTL and testbench

CDC_FRAME_ARBITER -- requirements
Module: cdc_frame_arbiter

---
 rtl/cdc_frame_arbiter.sv | 149 ++++++++++++++
 tb/tb_cdc_frame_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_frame_arbiter.sv
// Round-robin frame arbiter that merges two byte requesters onto one CDC FIFO write port.
// Over-length frames are truncated and their tail drained; frames that go idle mid-transfer are aborted.
module cdc_frame_arbiter #(
   parameter int MAX_FRAME_LEN = 1518,
   parameter int STALL_TIMEOUT = 64
) (
   input  logic       clkIn,
   input  logic       rstIn,
   input  logic       req0ValidIn,
   input  logic [7:0] req0DataIn,
   input  logic       req0LastIn,
   output logic       req0ReadyOut,
   input  logic       req1ValidIn,
   input  logic [7:0] req1DataIn,
   input  logic       req1LastIn,
   output logic       req1ReadyOut,
   input  logic       cdcReadyIn,
   output logic       wrEnOut,
   output logic [7:0] wrDataOut,
   output logic       wrLastOut,
   output logic       wrSrcOut,
   output logic       errTruncOut,
   output logic       errStallOut
);
   localparam logic [15:0] MAX_LEN   = 16'(MAX_FRAME_LEN);
   localparam logic [15:0] STALL_LIM = 16'(STALL_TIMEOUT);

   typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

   state_t      state_q, state_d;
   logic        grant_q, grant_d;
   logic        last_grant_q, last_grant_d;
   logic [15:0] len_q, len_d;
   logic [15:0] stall_q, stall_d;
   logic        wr_en_q, wr_en_d;
   logic [7:0]  wr_data_q, wr_data_d;
   logic        wr_last_q, wr_last_d;
   logic        wr_src_q, wr_src_d;
   logic        err_trunc_q, err_trunc_d;
   logic        err_stall_q, err_stall_d;

   logic        g_valid, g_last, g_ready, accept;
   logic [7:0]  g_data;
   logic [15:0] len_inc, stall_inc;

   // Granted requester's view; in DRAIN the tail is swallowed regardless of the CDC.
   always_comb begin
      g_valid   = grant_q ? req1ValidIn : req0ValidIn;
      g_data    = grant_q ? req1DataIn  : req0DataIn;
      g_last    = grant_q ? req1LastIn  : req0LastIn;
      g_ready   = (state_q == DRAIN) || ((state_q == XFER) && cdcReadyIn);
      accept    = g_valid && g_ready;
      len_inc   = len_q + 16'd1;
      stall_inc = stall_q + 16'd1;
   end

   assign req0ReadyOut = g_ready && !grant_q;
   assign req1ReadyOut = g_ready && grant_q;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      len_d        = len_q;
      stall_d      = stall_q;
      wr_en_d      = 1'b0;
      wr_data_d    = wr_data_q;
      wr_last_d    = 1'b0;
      wr_src_d     = 1'b0;
      err_trunc_d  = 1'b0;
      err_stall_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0ValidIn || req1ValidIn) begin
               grant_d = (req0ValidIn && req1ValidIn) ? !last_grant_q : req1ValidIn;
               len_d   = 16'd0;
               stall_d = 16'd0;
               state_d = XFER;
            end
         end
         XFER: begin
            if (accept) begin
               wr_en_d   = 1'b1;
               wr_data_d = g_data;
               wr_src_d  = grant_q;
               len_d     = len_inc;
               stall_d   = 16'd0;
               if (g_last) begin
                  wr_last_d    = 1'b1;
                  last_grant_d = grant_q;
                  state_d      = IDLE;
               end else if (len_inc == MAX_LEN) begin
                  wr_last_d    = 1'b1;
                  err_trunc_d  = 1'b1;
                  last_grant_d = grant_q;
                  state_d      = DRAIN;
               end
            end else if (!g_valid) begin
               // Back-pressure from the CDC is not a stall; only a silent requester is.
               stall_d = stall_inc;
               if (stall_inc == STALL_LIM) begin
                  err_stall_d  = 1'b1;
                  last_grant_d = grant_q;
                  state_d      = IDLE;
               end
            end
         end
         DRAIN: begin
            if (accept && g_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clkIn) begin
      if (rstIn) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         len_q        <= 16'd0;
         stall_q      <= 16'd0;
         wr_en_q      <= 1'b0;
         wr_data_q    <= 8'h00;
         wr_last_q    <= 1'b0;
         wr_src_q     <= 1'b0;
         err_trunc_q  <= 1'b0;
         err_stall_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         len_q        <= len_d;
         stall_q      <= stall_d;
         wr_en_q      <= wr_en_d;
         wr_data_q    <= wr_data_d;
         wr_last_q    <= wr_last_d;
         wr_src_q     <= wr_src_d;
         err_trunc_q  <= err_trunc_d;
         err_stall_q  <= err_stall_d;
      end
   end

   assign wrEnOut     = wr_en_q;
   assign wrDataOut   = wr_data_q;
   assign wrLastOut   = wr_last_q;
   assign wrSrcOut    = wr_src_q;
   assign errTruncOut = err_trunc_q;
   assign errStallOut = err_stall_q;
endmodule

// File: tb/tb_cdc_frame_arbiter.sv
// Bench for cdc_frame_arbiter: directed frame scenarios plus a randomized soak, all
// checked cycle by cycle against a transaction-level model of the arbitration rules.
module tb_cdc_frame_arbiter;
   localparam int MAXL  = 4;
   localparam int STALL = 8;

   logic       clk = 1'b0;
   logic       rstIn;
   logic       req0ValidIn, req0LastIn, req0ReadyOut;
   logic [7:0] req0DataIn;
   logic       req1ValidIn, req1LastIn, req1ReadyOut;
   logic [7:0] req1DataIn;
   logic       cdcReadyIn;
   logic       wrEnOut, wrLastOut, wrSrcOut, errTruncOut, errStallOut;
   logic [7:0] wrDataOut;

   always #5 clk = ~clk;

   cdc_frame_arbiter #(.MAX_FRAME_LEN(MAXL), .STALL_TIMEOUT(STALL)) dut (
      .clkIn(clk), .rstIn(rstIn),
      .req0ValidIn(req0ValidIn), .req0DataIn(req0DataIn), .req0LastIn(req0LastIn), .req0ReadyOut(req0ReadyOut),
      .req1ValidIn(req1ValidIn), .req1DataIn(req1DataIn), .req1LastIn(req1LastIn), .req1ReadyOut(req1ReadyOut),
      .cdcReadyIn(cdcReadyIn),
      .wrEnOut(wrEnOut), .wrDataOut(wrDataOut), .wrLastOut(wrLastOut), .wrSrcOut(wrSrcOut),
      .errTruncOut(errTruncOut), .errStallOut(errStallOut)
   );

   int n_vec = 0, n_err = 0, n_trunc = 0, n_stall = 0;
   logic [8:0] q0[$], q1[$];        // {last, data} byte sources
   logic [9:0] cap[$], expq[$];     // {src, last, data} written bytes
   bit en0 = 0, en1 = 0, gapmode = 0, checking = 0;
   int pause0 = 0, pause1 = 0;

   // Model: who owns the port (-1 = nobody), whether the tail is being dropped,
   // bytes forwarded so far, consecutive silent cycles, and the last frame winner.
   int m_owner = -1, m_prev = 1, m_nbytes = 0, m_idle = 0;
   bit m_drain = 0;
   logic e_wr_en = 0, e_last = 0, e_src = 0, e_tr = 0, e_st = 0;
   logic [7:0] e_data = 8'h00;

   task automatic chkb(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_frame(input int r, input logic [7:0] base, input int len, input bit term);
      for (int i = 0; i < len; i++) begin
         logic [8:0] e;
         e = {term && (i == len - 1), 8'(base + 8'(i))};
         if (r == 0) q0.push_back(e); else q1.push_back(e);
      end
   endtask

   task automatic drive();
      logic v0, v1;
      if (pause0 > 0) pause0--;
      if (pause1 > 0) pause1--;
      v0 = en0 && (q0.size() > 0) && (pause0 == 0) && !(gapmode && $urandom_range(0, 3) == 0);
      v1 = en1 && (q1.size() > 0) && (pause1 == 0) && !(gapmode && $urandom_range(0, 3) == 0);
      req0ValidIn = v0;
      req0DataIn  = v0 ? q0[0][7:0] : 8'h00;
      req0LastIn  = v0 ? q0[0][8] : 1'b0;
      req1ValidIn = v1;
      req1DataIn  = v1 ? q1[0][7:0] : 8'h00;
      req1LastIn  = v1 ? q1[0][8] : 1'b0;
   endtask

   task automatic check_outputs();
      logic r0, r1;
      r0 = (m_owner == 0) && (m_drain || cdcReadyIn);
      r1 = (m_owner == 1) && (m_drain || cdcReadyIn);
      chkb("req0Ready", req0ReadyOut, r0);
      chkb("req1Ready", req1ReadyOut, r1);
      chkb("wrEn", wrEnOut, e_wr_en);
      chkw("wrData", 16'(wrDataOut), 16'(e_data));
      chkb("wrLast", wrLastOut, e_last);
      chkb("wrSrc", wrSrcOut, e_src);
      chkb("errTrunc", errTruncOut, e_tr);
      chkb("errStall", errStallOut, e_st);
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      logic v[2], l[2];
      logic [7:0] d[2];
      int g;
      bit acc;
      v[0] = req0ValidIn; v[1] = req1ValidIn;
      l[0] = req0LastIn;  l[1] = req1LastIn;
      d[0] = req0DataIn;  d[1] = req1DataIn;
      g = (m_owner < 0) ? 0 : m_owner;
      acc = (m_owner >= 0) && v[g] && (m_drain || cdcReadyIn);
      e_wr_en = 0; e_last = 0; e_src = 0; e_tr = 0; e_st = 0;
      if (rstIn) begin
         m_owner = -1; m_drain = 0; m_prev = 1; m_nbytes = 0; m_idle = 0; e_data = 8'h00;
      end else if (m_owner < 0) begin
         if (v[0] || v[1]) begin
            m_owner = (v[0] && v[1]) ? 1 - m_prev : (v[1] ? 1 : 0);
            m_nbytes = 0; m_idle = 0; m_drain = 0;
         end
      end else if (m_drain) begin
         if (acc && l[g]) m_owner = -1;
      end else if (acc) begin
         e_wr_en = 1; e_data = d[g]; e_src = 1'(g);
         m_nbytes++; m_idle = 0;
         if (l[g]) begin
            e_last = 1; m_prev = g; m_owner = -1;
         end else if (m_nbytes == MAXL) begin
            e_last = 1; e_tr = 1; m_prev = g; m_drain = 1;
         end
      end else if (!v[g]) begin
         m_idle++;
         if (m_idle == STALL) begin
            e_st = 1; m_prev = g; m_owner = -1;
         end
      end
   endtask

   task automatic cycle();
      bit f0, f1;
      drive();
      @(negedge clk);
      if (checking) check_outputs();
      if (wrEnOut === 1'b1) cap.push_back({wrSrcOut, wrLastOut, wrDataOut});
      if (errTruncOut === 1'b1) n_trunc++;
      if (errStallOut === 1'b1) n_stall++;
      model_step();
      f0 = (req0ValidIn === 1'b1) && (req0ReadyOut === 1'b1);
      f1 = (req1ValidIn === 1'b1) && (req1ReadyOut === 1'b1);
      @(posedge clk);
      #1;
      if (f0 && q0.size() > 0) void'(q0.pop_front());
      if (f1 && q1.size() > 0) void'(q1.pop_front());
   endtask

   task automatic run_until_empty(input string tag, input int budget);
      int n = 0;
      while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin
         cycle();
         n++;
      end
      chkb({tag, "_in_time"}, n < budget, 1'b1);
      repeat (3) cycle();
   endtask

   task automatic cmp_cap(input string tag);
      chkw({tag, "_count"}, 16'(cap.size()), 16'(expq.size()));
      for (int i = 0; i < expq.size() && i < cap.size(); i++)
         chkw($sformatf("%s_byte%0d", tag, i), 16'(cap[i]), 16'(expq[i]));
      cap.delete();
      expq.delete();
   endtask

   initial begin
      rstIn = 1'b1; cdcReadyIn = 1'b1;
      req0ValidIn = 0; req0DataIn = 0; req0LastIn = 0;
      req1ValidIn = 0; req1DataIn = 0; req1LastIn = 0;
      @(posedge clk); #1;
      repeat (2) cycle();
      checking = 1;
      cycle();
      chkb("rst_wrEn", wrEnOut, 1'b0);
      chkw("rst_wrData", 16'(wrDataOut), 16'h0000);
      chkb("rst_ready0", req0ReadyOut, 1'b0);

      // Round-robin: A(req0) then B(req1), then req0 again after B.
      push_frame(0, 8'hA1, 3, 1); push_frame(0, 8'hC1, 1, 1);
      push_frame(1, 8'hB1, 1, 1); push_frame(1, 8'hD1, 1, 1);
      en0 = 1; en1 = 1; rstIn = 1'b0;
      run_until_empty("rr", 60);
      expq.push_back({2'b00, 8'hA1}); expq.push_back({2'b00, 8'hA2}); expq.push_back({2'b01, 8'hA3});
      expq.push_back({2'b11, 8'hB1}); expq.push_back({2'b01, 8'hC1}); expq.push_back({2'b11, 8'hD1});
      cmp_cap("rr");

      // Truncation of a 6-byte frame at MAX_FRAME_LEN=4.
      n_trunc = 0; n_stall = 0;
      push_frame(0, 8'h40, 6, 1);
      run_until_empty("trunc", 40);
      expq.push_back({2'b00, 8'h40}); expq.push_back({2'b00, 8'h41});
      expq.push_back({2'b00, 8'h42}); expq.push_back({2'b01, 8'h43});
      cmp_cap("trunc");
      chkw("trunc_pulses", 16'(n_trunc), 16'd1);

      // Stall abort on req1, then req0 wins the next tie.
      n_stall = 0;
      push_frame(1, 8'h50, 2, 0);
      run_until_empty("stall_tx", 40);
      repeat (10) cycle();
      chkw("stall_pulses", 16'(n_stall), 16'd1);
      expq.push_back({2'b10, 8'h50}); expq.push_back({2'b10, 8'h51});
      cmp_cap("stall");
      push_frame(0, 8'h60, 1, 1); push_frame(1, 8'h52, 1, 1);
      run_until_empty("after_stall", 40);
      expq.push_back({2'b01, 8'h60}); expq.push_back({2'b11, 8'h52});
      cmp_cap("after_stall");

      // CDC back-pressure mid-frame is not a stall; a 4-byte frame with last is not truncated.
      n_stall = 0; n_trunc = 0;
      push_frame(0, 8'h70, 4, 1);
      repeat (2) cycle();
      cdcReadyIn = 1'b0;
      repeat (20) cycle();
      chkw("bp_remaining", 16'(q0.size()), 16'd3);
      chkw("bp_stall", 16'(n_stall), 16'd0);
      cdcReadyIn = 1'b1;
      run_until_empty("bp", 40);
      expq.push_back({2'b00, 8'h70}); expq.push_back({2'b00, 8'h71});
      expq.push_back({2'b00, 8'h72}); expq.push_back({2'b01, 8'h73});
      cmp_cap("bp");
      chkw("bp_trunc", 16'(n_trunc), 16'd0);

      // Reset mid-frame, then a fresh 3-byte frame must not be truncated.
      push_frame(0, 8'h80, 5, 1);
      for (int n = 0; n < 30 && cap.size() < 2; n++) cycle();
      chkb("mid_rst_progress", cap.size() >= 2, 1'b1);
      rstIn = 1'b1;
      cycle();
      rstIn = 1'b0;
      q0.delete();
      chkb("mrst_wrEn", wrEnOut, 1'b0);
      chkb("mrst_wrLast", wrLastOut, 1'b0);
      chkb("mrst_wrSrc", wrSrcOut, 1'b0);
      chkw("mrst_wrData", 16'(wrDataOut), 16'h0000);
      chkb("mrst_errTrunc", errTruncOut, 1'b0);
      chkb("mrst_errStall", errStallOut, 1'b0);
      chkb("mrst_ready0", req0ReadyOut, 1'b0);
      chkb("mrst_ready1", req1ReadyOut, 1'b0);
      cap.delete();
      n_trunc = 0;
      push_frame(0, 8'h90, 3, 1);
      run_until_empty("post_rst", 40);
      expq.push_back({2'b00, 8'h90}); expq.push_back({2'b00, 8'h91}); expq.push_back({2'b01, 8'h92});
      cmp_cap("post_rst");
      chkw("post_rst_trunc", 16'(n_trunc), 16'd0);

      // Randomized soak against the model.
      gapmode = 1;
      for (int c = 0; c < 1500; c++) begin
         if (q0.size() < 4) push_frame(0, 8'($urandom), $urandom_range(1, 6), 1);
         if (q1.size() < 4) push_frame(1, 8'($urandom), $urandom_range(1, 6), 1);
         if ($urandom_range(0, 63) == 0) pause0 = $urandom_range(1, 12);
         if ($urandom_range(0, 63) == 0) pause1 = $urandom_range(1, 12);
         cdcReadyIn = ($urandom_range(0, 3) != 0);
         rstIn = ($urandom_range(0, 499) == 0);
         cycle();
         if (cap.size() > 64) cap.delete();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
